// File: rtl/kzg_pkg.sv
// Shared types, widths and the Q16 output narrowing used by kzg_accum.
// Output saturation is selected by the KZG_ACCUM_SAT_EN macro.
package kzg_pkg;

  localparam int Q16_FRAC = 16;
  localparam int KZG_W    = 32;
  localparam int P_W      = 2 * KZG_W - Q16_FRAC;

  typedef struct packed {
    logic signed [KZG_W-1:0] x;
    logic signed [KZG_W-1:0] y;
    logic signed [KZG_W-1:0] z;
  } kzg_vec_t;

  typedef struct packed {
    logic [KZG_W-1:0] val;
    logic             ovf;
  } narrow_t;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_ACCUM,
    ST_DRAIN,
    ST_HOLD
  } kzg_state_e;

  // In range iff all bits from the 32-bit sign bit upward agree.
  function automatic narrow_t narrow_q16(input logic signed [63:0] v);
    narrow_t r;
    r.ovf = !((&v[63:KZG_W-1]) || !(|v[63:KZG_W-1]));
    r.val = v[KZG_W-1:0];
`ifdef KZG_ACCUM_SAT_EN
    if (r.ovf) begin
      r.val = v[63] ? {1'b1, {(KZG_W-1){1'b0}}} : {1'b0, {(KZG_W-1){1'b1}}};
    end
`endif
    return r;
  endfunction

endpackage

// File: rtl/kzg_accum_wmul.sv
// Registered signed 32x32 Q16 multiply with valid pass-through.
// Result is the 64-bit product shifted right 16 (floor), kept as 48 bits.
module kzg_wmul
  import kzg_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic signed [KZG_W-1:0] a,
  input  logic signed [KZG_W-1:0] b,
  output logic                    out_valid,
  output logic signed [P_W-1:0]   p
);

  logic signed [2*KZG_W-1:0] prod;
  logic signed [P_W-1:0]     p_d, p_q;
  logic                      vld_d, vld_q;

  always_comb begin
    prod  = $signed({{KZG_W{a[KZG_W-1]}}, a}) * $signed({{KZG_W{b[KZG_W-1]}}, b});
    p_d   = P_W'(prod >>> Q16_FRAC);
    vld_d = in_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      p_q   <= p_d;
      vld_q <= vld_d;
    end
  end

  assign p         = p_q;
  assign out_valid = vld_q;

endmodule

// File: rtl/kzg_accum.sv
// Weighted K_ZG vector accumulator: multiply, accumulate per set, emit on valid/ready.
// Build option KZG_ACCUM_SAT_EN clamps the narrowed 32-bit sums instead of wrapping.
module kzg_accum
  import kzg_pkg::*;
#(
  parameter int ACC_W = 48,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [31:0]      kzg_x,
  input  logic [31:0]      kzg_y,
  input  logic [31:0]      kzg_z,
  input  logic [31:0]      weight,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      sum_x,
  output logic [31:0]      sum_y,
  output logic [31:0]      sum_z,
  output logic [CNT_W-1:0] pt_count,
  output logic             ovf
);

  kzg_state_e state_q, state_d;

  logic                    accept;
  logic signed [KZG_W-1:0] kin [3];
  logic [2:0]              mul_vld;
  logic signed [P_W-1:0]   mul_p [3];
  logic                    s1_valid;

  logic                    s1_last_d, s1_last_q;
  logic                    s2_last_d, s2_last_q;
  logic                    first_d, first_q;
  logic [CNT_W-1:0]        cnt_d, cnt_q;
  logic signed [ACC_W-1:0] acc_d [3];
  logic signed [ACC_W-1:0] acc_q [3];
  logic                    ovf_acc_d, ovf_acc_q;

  kzg_vec_t                sum_d, sum_q;
  logic [CNT_W-1:0]        cnt_out_d, cnt_out_q;
  logic                    ovf_out_d, ovf_out_q;

  logic signed [ACC_W-1:0] base [3];
  logic signed [ACC_W:0]   sum_w [3];
  logic [2:0]              add_ovf;
  narrow_t                 nr [3];

  assign kin[0]   = $signed(kzg_x);
  assign kin[1]   = $signed(kzg_y);
  assign kin[2]   = $signed(kzg_z);
  assign accept   = in_valid & in_ready;
  assign s1_valid = &mul_vld;

  for (genvar g = 0; g < 3; g++) begin : g_mul
    kzg_wmul u_mul (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (accept),
      .a        (kin[g]),
      .b        ($signed(weight)),
      .out_valid(mul_vld[g]),
      .p        (mul_p[g])
    );
  end

  // Stage 2 datapath; the FSM section below may override first_d.
  always_comb begin
    s1_last_d = accept & in_last;
    s2_last_d = s1_valid & s1_last_q;
    first_d   = first_q;
    cnt_d     = cnt_q;
    ovf_acc_d = ovf_acc_q;
    acc_d     = acc_q;
    add_ovf   = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      base[i]    = first_q ? '0 : acc_q[i];
      sum_w[i]   = (ACC_W+1)'(base[i]) + (ACC_W+1)'(ACC_W'(mul_p[i]));
      add_ovf[i] = sum_w[i][ACC_W] ^ sum_w[i][ACC_W-1];
      nr[i]      = narrow_q16(64'(acc_q[i]));
    end
    if (s1_valid) begin
      for (int unsigned i = 0; i < 3; i++) begin
        acc_d[i] = sum_w[i][ACC_W-1:0];
      end
      ovf_acc_d = (first_q ? 1'b0 : ovf_acc_q) | (|add_ovf);
      if (first_q) begin
        cnt_d = CNT_W'(1);
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      first_d = 1'b0;
    end

    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    sum_d     = sum_q;
    cnt_out_d = cnt_out_q;
    ovf_out_d = ovf_out_q;
    unique case (state_q)
      ST_INIT: state_d = ST_ACCUM;
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (accept && in_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (s2_last_q) begin
          sum_d.x   = nr[0].val;
          sum_d.y   = nr[1].val;
          sum_d.z   = nr[2].val;
          cnt_out_d = cnt_q;
          ovf_out_d = ovf_acc_q | nr[0].ovf | nr[1].ovf | nr[2].ovf;
          first_d   = 1'b1;
          state_d   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_ACCUM;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      s1_last_q <= 1'b0;
      s2_last_q <= 1'b0;
      first_q   <= 1'b1;
      cnt_q     <= '0;
      acc_q     <= '{default: '0};
      ovf_acc_q <= 1'b0;
      sum_q     <= '0;
      cnt_out_q <= '0;
      ovf_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s1_last_q <= s1_last_d;
      s2_last_q <= s2_last_d;
      first_q   <= first_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      ovf_acc_q <= ovf_acc_d;
      sum_q     <= sum_d;
      cnt_out_q <= cnt_out_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  assign sum_x    = sum_q.x;
  assign sum_y    = sum_q.y;
  assign sum_z    = sum_q.z;
  assign pt_count = cnt_out_q;
  assign ovf      = ovf_out_q;

endmodule

// File: tb/tb_kzg_accum.sv
// Self-checking bench for kzg_accum: directed sets plus randomized sets against
// an integer reference model of the weighted sum, wrap/overflow and narrowing.
module tb_kzg_accum;

  localparam longint ACC_MAX  = (longint'(1) <<< 47) - 1;
  localparam longint ACC_MIN  = -(longint'(1) <<< 47);
  localparam longint ACC_SPAN = longint'(1) <<< 48;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, in_last, out_valid, out_ready, ovf;
  logic [31:0] kzg_x, kzg_y, kzg_z, weight, sum_x, sum_y, sum_z;
  logic [15:0] pt_count;

  always #5 clk = ~clk;

  kzg_accum #(.ACC_W(48), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .kzg_x(kzg_x), .kzg_y(kzg_y), .kzg_z(kzg_z),
    .weight(weight), .out_valid(out_valid), .out_ready(out_ready),
    .sum_x(sum_x), .sum_y(sum_y), .sum_z(sum_z), .pt_count(pt_count), .ovf(ovf)
  );

  int tests = 0;
  int fails = 0;
  logic [31:0] bx[$], by[$], bz[$], bw[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint wprod(input logic [31:0] k, input logic [31:0] w);
    return (longint'($signed(k)) * longint'($signed(w))) >>> 16;
  endfunction

  // Result layout: {x[31:0], y[31:0], z[31:0], count[15:0], ovf}
  function automatic logic [112:0] model_out();
    logic [31:0] o [3];
    logic [15:0] cnt;
    bit          ov = 1'b0;
    longint      w;
    for (int c = 0; c < 3; c++) begin
      w = 0;
      for (int i = 0; i < bx.size(); i++) begin
        w += wprod((c == 0) ? bx[i] : (c == 1) ? by[i] : bz[i], bw[i]);
        if (w > ACC_MAX) begin w -= ACC_SPAN; ov = 1'b1; end
        else if (w < ACC_MIN) begin w += ACC_SPAN; ov = 1'b1; end
      end
      o[c] = w[31:0];
      if (w > 64'sd2147483647 || w < -64'sd2147483648) begin
        ov = 1'b1;
`ifdef KZG_ACCUM_SAT_EN
        o[c] = (w < 0) ? 32'h80000000 : 32'h7FFFFFFF;
`endif
      end
    end
    cnt = (bx.size() > 65535) ? 16'hFFFF : 16'(bx.size());
    return {o[0], o[1], o[2], cnt, ov};
  endfunction

  function automatic logic [31:0] rnd_val();
    if ($urandom_range(0, 3) == 0) return $urandom();
    return 32'(int'($urandom_range(0, 524288)) - 262144);
  endfunction

  task automatic junk();
    kzg_x = $urandom(); kzg_y = $urandom(); kzg_z = $urandom(); weight = $urandom();
    in_last = 1'($urandom_range(0, 1));
  endtask

  task automatic fill_random(input int n);
    bx = {}; by = {}; bz = {}; bw = {};
    for (int i = 0; i < n; i++) begin
      bx.push_back(rnd_val()); by.push_back(rnd_val());
      bz.push_back(rnd_val()); bw.push_back(rnd_val());
    end
  endtask

  task automatic drive_beat(input int i, input bit last, output bit ok);
    int guard = 0;
    ok = 1'b0;
    in_valid = 1'b1; in_last = last;
    kzg_x = bx[i]; kzg_y = by[i]; kzg_z = bz[i]; weight = bw[i];
    while (!ok && guard < 50) begin
      ok = in_ready;
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic run_set(input string tag, input int max_gap, input int bp_lo, input int bp_hi,
                         input bit hold_valid, output logic [112:0] got);
    logic [112:0] exp;
    bit           ok;
    int           guard;
    exp = model_out();
    for (int i = 0; i < bx.size(); i++) begin
      repeat ($urandom_range(0, max_gap)) begin
        in_valid = 1'b0; junk(); @(posedge clk); #1;
      end
      drive_beat(i, i == bx.size() - 1, ok);
      check({tag, " accept"}, 128'(ok), 128'(1));
    end
    junk(); in_last = 1'b0;
    check({tag, " lat_t1"}, 128'(out_valid), 128'(0));
    @(posedge clk); #1;
    check({tag, " lat_t2"}, 128'(out_valid), 128'(0));
    @(posedge clk); #1;
    check({tag, " lat_t3"}, 128'(out_valid), 128'(1));
    guard = 0;
    while (!out_valid && guard < 20) begin @(posedge clk); #1; guard++; end
    got = {sum_x, sum_y, sum_z, pt_count, ovf};
    check({tag, " result"}, 128'(got), 128'(exp));
    repeat ($urandom_range(bp_lo, bp_hi)) begin
      in_valid = hold_valid | 1'($urandom_range(0, 1));
      junk(); in_last = 1'b0;
      @(posedge clk); #1;
      check({tag, " hold"}, 128'({out_valid, in_ready, sum_x, sum_y, sum_z, pt_count, ovf}),
            128'({2'b10, exp}));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " release"}, 128'({out_valid, in_ready}), 128'(2'b01));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [112:0] got;
    bit           ok;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    kzg_x = '0; kzg_y = '0; kzg_z = '0; weight = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_state", 128'({in_ready, out_valid, sum_x, sum_y, sum_z, pt_count, ovf}), 128'(0));
    @(posedge clk); #1;
    check("reset_in_ready_up", 128'(in_ready), 128'(1));

    // 1: three beats of 1.0 * 2.0
    bx = {32'h00010000, 32'h00010000, 32'h00010000};
    by = {32'h0, 32'h0, 32'h0}; bz = {32'h0, 32'h0, 32'h0};
    bw = {32'h00020000, 32'h00020000, 32'h00020000};
    run_set("t1", 0, 0, 0, 1'b0, got);
    check("t1 sum_x", 128'(got[112:81]), 128'(32'h00060000));
    check("t1 count", 128'(got[16:1]), 128'(16'd3));
    check("t1 ovf", 128'(got[0]), 128'(0));

    // 2: one-beat set
    bx = {32'hFFFE8000}; by = {32'h00008000}; bz = {32'h0}; bw = {32'h00010000};
    run_set("t2", 0, 1, 2, 1'b0, got);
    check("t2 sums", 128'(got[112:17]), 128'({32'hFFFE8000, 32'h00008000, 32'h0}));
    check("t2 count", 128'(got[16:1]), 128'(16'd1));

    // 3: ten cycles of back-pressure with in_valid held high, then a clean set
    fill_random(3);
    run_set("t3", 0, 10, 10, 1'b1, got);
    fill_random(4);
    run_set("t3_next", 1, 0, 0, 1'b0, got);

    // 4: accumulator overflow
    bx = {32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF};
    by = {32'h0, 32'h0, 32'h0, 32'h0}; bz = {32'h0, 32'h0, 32'h0, 32'h0};
    bw = {32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF};
    run_set("t4", 0, 0, 1, 1'b0, got);
    check("t4 ovf", 128'(got[0]), 128'(1));
`ifndef KZG_ACCUM_SAT_EN
    check("t4 sum_x_wrap", 128'(got[112:81]), 128'(32'hFFFC0000));
`endif

    // 5: reset after beat 2 of a 5-beat set
    fill_random(5);
    drive_beat(0, 1'b0, ok);
    drive_beat(1, 1'b0, ok);
    rst_n = 1'b0;
    #1;
    check("t5 in_reset", 128'({out_valid, in_ready, sum_x, pt_count, ovf}), 128'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      check("t5 no_output", 128'(out_valid), 128'(0));
    end
    fill_random(1);
    run_set("t5_after", 0, 0, 1, 1'b0, got);
    check("t5 count", 128'(got[16:1]), 128'(16'd1));

    // 6: randomized sets with gaps and back-pressure
    for (int s = 0; s < 1000; s++) begin
      fill_random($urandom_range(1, 8));
      run_set("t6", 2, 0, 3, 1'b0, got);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
